log_hdr_mem_arbiter: RTL and testbench



---
 rtl/log_hdr_mem_arbiter_pkg.sv | 19 +
 rtl/rr_grant_sel.sv | 40 ++++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/log_hdr_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_log_hdr_mem_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/log_hdr_mem_arbiter_pkg.sv
// Log-header record types shared by the VR log blocks, plus round-robin helpers for the header memory arbiter.
package beehive_vr_pkg;
    localparam int LOG_HDR_DEPTH_W = 8;

    typedef struct packed {
        logic [15:0] view;
        logic [31:0] op_num;
        logic [15:0] payload_len;
    } log_entry_hdr;

    localparam int LOG_ENTRY_HDR_W = $bits(log_entry_hdr);
endpackage

package log_hdr_mem_arbiter_pkg;
    // Both operands are already below n, so a single conditional subtract replaces a modulo.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction
endpackage

// File: rtl/rr_grant_sel.sv
// Round-robin selector: picks the first valid requester at or after ptr, wrapping around.
module rr_grant_sel
    import log_hdr_mem_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int CLIENT_W = $clog2(N)
) (
    input  logic [N-1:0]        valid,
    input  logic [CLIENT_W-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [CLIENT_W-1:0] idx,
    output logic                any
);
    logic [N-1:0]        rot_valid;
    logic [CLIENT_W-1:0] rot_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi]   = CLIENT_W'(rr_wrap(int'(ptr) + gi, N));
            assign rot_valid[gi] = valid[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        grant = '0;
        // Scan from the far end so the nearest offset to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                idx = rot_idx[k];
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; used as the outstanding-read tag queue.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             push_en, pop_en;

    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_next = count_reg + 1'b1;
        end else if (!push_en && pop_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end
endmodule

// File: rtl/log_hdr_mem_arbiter.sv
// Shares the log header memory read/write ports between NUM_CLIENTS requesters with in-order read responses.
// Optional LOG_HDR_ARB_LOCK_EN adds cl_lock for atomic multi-access sequences; LOG_HDR_ARB_SVA enables the tagless-response check.
module log_hdr_mem_arbiter
    import beehive_vr_pkg::*;
    import log_hdr_mem_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS    = 3,
    parameter int CLIENT_W       = $clog2(NUM_CLIENTS),
    parameter int TAG_FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
`ifdef LOG_HDR_ARB_LOCK_EN
    input  logic [NUM_CLIENTS-1:0]                 cl_lock,
`endif
    input  logic [NUM_CLIENTS-1:0]                 cl_rd_req_val,
    input  logic [NUM_CLIENTS*LOG_HDR_DEPTH_W-1:0] cl_rd_req_addr,
    output logic [NUM_CLIENTS-1:0]                 arb_cl_rd_req_rdy,
    output logic [NUM_CLIENTS-1:0]                 arb_cl_rd_resp_val,
    output logic [LOG_ENTRY_HDR_W-1:0]             arb_cl_rd_resp_data,
    input  logic [NUM_CLIENTS-1:0]                 cl_rd_resp_rdy,
    input  logic [NUM_CLIENTS-1:0]                 cl_wr_val,
    input  logic [NUM_CLIENTS*LOG_HDR_DEPTH_W-1:0] cl_wr_addr,
    input  logic [NUM_CLIENTS*LOG_ENTRY_HDR_W-1:0] cl_wr_data,
    output logic [NUM_CLIENTS-1:0]                 arb_cl_wr_rdy,
    output logic                                   arb_mem_rd_req_val,
    output logic [LOG_HDR_DEPTH_W-1:0]             arb_mem_rd_req_addr,
    input  logic                                   mem_arb_rd_req_rdy,
    input  logic                                   mem_arb_rd_resp_val,
    input  logic [LOG_ENTRY_HDR_W-1:0]             mem_arb_rd_resp_data,
    output logic                                   arb_mem_rd_resp_rdy,
    output logic                                   arb_mem_wr_val,
    output logic [LOG_HDR_DEPTH_W-1:0]             arb_mem_wr_addr,
    output logic [LOG_ENTRY_HDR_W-1:0]             arb_mem_wr_data,
    input  logic                                   mem_arb_wr_rdy
);
    logic [LOG_HDR_DEPTH_W-1:0] rd_addr_arr  [NUM_CLIENTS];
    logic [LOG_HDR_DEPTH_W-1:0] wr_addr_arr  [NUM_CLIENTS];
    log_entry_hdr               wr_data_arr  [NUM_CLIENTS];

    logic [CLIENT_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CLIENT_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [NUM_CLIENTS-1:0] lock_mask, rd_elig, wr_elig;
    logic [NUM_CLIENTS-1:0] rd_grant, wr_grant;
    logic [CLIENT_W-1:0]    rd_idx, wr_idx;
    logic                   rd_any, wr_any;
    logic [LOG_HDR_DEPTH_W-1:0] rd_addr;
    logic                   wr_hs, hazard, rd_go, rd_hs;
    logic                   tag_full, tag_empty, tag_pop, resp_hs;
    logic [CLIENT_W-1:0]    tag_head;
    logic [NUM_CLIENTS-1:0] head_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign rd_addr_arr[gi] = cl_rd_req_addr[gi*LOG_HDR_DEPTH_W +: LOG_HDR_DEPTH_W];
            assign wr_addr_arr[gi] = cl_wr_addr[gi*LOG_HDR_DEPTH_W +: LOG_HDR_DEPTH_W];
            assign wr_data_arr[gi] = cl_wr_data[gi*LOG_ENTRY_HDR_W +: LOG_ENTRY_HDR_W];
        end
    endgenerate

`ifdef LOG_HDR_ARB_LOCK_EN
    // The lock follows whoever last won either port; it is sampled so it drops one cycle after cl_lock does.
    logic [CLIENT_W-1:0] owner_reg, owner_next;
    logic                owner_vld_reg, owner_vld_next;
    logic                locked_reg, locked_next;

    always_comb begin
        owner_next     = owner_reg;
        owner_vld_next = owner_vld_reg;
        if (rd_hs) begin
            owner_next     = rd_idx;
            owner_vld_next = 1'b1;
        end else if (wr_hs) begin
            owner_next     = wr_idx;
            owner_vld_next = 1'b1;
        end
        locked_next = owner_vld_next & cl_lock[owner_next];
        lock_mask   = '1;
        if (locked_reg) begin
            lock_mask            = '0;
            lock_mask[owner_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg     <= '0;
            owner_vld_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            owner_reg     <= owner_next;
            owner_vld_reg <= owner_vld_next;
            locked_reg    <= locked_next;
        end
    end
`else
    assign lock_mask = '1;
`endif

    assign rd_elig = cl_rd_req_val & lock_mask;
    assign wr_elig = cl_wr_val & lock_mask;

    rr_grant_sel #(.N(NUM_CLIENTS), .CLIENT_W(CLIENT_W)) u_rd_sel (
        .valid (rd_elig),
        .ptr   (rd_ptr_reg),
        .grant (rd_grant),
        .idx   (rd_idx),
        .any   (rd_any)
    );

    rr_grant_sel #(.N(NUM_CLIENTS), .CLIENT_W(CLIENT_W)) u_wr_sel (
        .valid (wr_elig),
        .ptr   (wr_ptr_reg),
        .grant (wr_grant),
        .idx   (wr_idx),
        .any   (wr_any)
    );

    // Write path: writes never stall on reads.
    assign arb_mem_wr_val  = wr_any & ~rst;
    assign arb_mem_wr_addr = wr_addr_arr[wr_idx];
    assign arb_mem_wr_data = wr_data_arr[wr_idx];
    assign wr_hs           = arb_mem_wr_val & mem_arb_wr_rdy;
    assign arb_cl_wr_rdy   = wr_hs ? wr_grant : '0;

    // Read path: a same-address write in this cycle holds the read back so it observes the new data.
    assign rd_addr             = rd_addr_arr[rd_idx];
    assign hazard              = wr_hs & rd_any & (rd_addr == arb_mem_wr_addr);
    assign rd_go               = rd_any & ~tag_full & ~hazard & ~rst;
    assign rd_hs               = rd_go & mem_arb_rd_req_rdy;
    assign arb_mem_rd_req_val  = rd_go;
    assign arb_mem_rd_req_addr = rd_addr;
    assign arb_cl_rd_req_rdy   = rd_hs ? rd_grant : '0;

    // Responses: with no tag outstanding, anything returned is a leftover and gets swallowed.
    assign head_onehot         = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << tag_head;
    assign arb_cl_rd_resp_val  = (!rst && !tag_empty && mem_arb_rd_resp_val) ? head_onehot : '0;
    assign arb_cl_rd_resp_data = mem_arb_rd_resp_data;
    assign arb_mem_rd_resp_rdy = ~rst & (tag_empty | cl_rd_resp_rdy[tag_head]);
    assign resp_hs             = mem_arb_rd_resp_val & arb_mem_rd_resp_rdy;
    assign tag_pop             = resp_hs & ~tag_empty;

    sync_fifo #(.WIDTH(CLIENT_W), .DEPTH(TAG_FIFO_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_hs),
        .push_data (rd_idx),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (rd_hs) begin
            rd_ptr_next = CLIENT_W'(rr_wrap(int'(rd_idx) + 1, NUM_CLIENTS));
        end
        if (wr_hs) begin
            wr_ptr_next = CLIENT_W'(rr_wrap(int'(wr_idx) + 1, NUM_CLIENTS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

`ifdef LOG_HDR_ARB_SVA
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_arb_rd_resp_val && tag_empty));
        end
    end
`endif
endmodule

// File: tb/tb_log_hdr_mem_arbiter.sv
// Randomized bench: the bench plays both the clients and the memory, and predicts every arbiter output from a queue-based model.
module tb_log_hdr_mem_arbiter;
    import beehive_vr_pkg::*;

    localparam int N     = 3;
    localparam int DW    = LOG_HDR_DEPTH_W;
    localparam int HW    = LOG_ENTRY_HDR_W;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      cl_rd_req_val = '0;
    logic [N*DW-1:0]   cl_rd_req_addr = '0;
    logic [N-1:0]      arb_cl_rd_req_rdy;
    logic [N-1:0]      arb_cl_rd_resp_val;
    logic [HW-1:0]     arb_cl_rd_resp_data;
    logic [N-1:0]      cl_rd_resp_rdy = '0;
    logic [N-1:0]      cl_wr_val = '0;
    logic [N*DW-1:0]   cl_wr_addr = '0;
    logic [N*HW-1:0]   cl_wr_data = '0;
    logic [N-1:0]      arb_cl_wr_rdy;
    logic              arb_mem_rd_req_val;
    logic [DW-1:0]     arb_mem_rd_req_addr;
    logic              mem_arb_rd_req_rdy = 1'b0;
    logic              mem_arb_rd_resp_val = 1'b0;
    logic [HW-1:0]     mem_arb_rd_resp_data = '0;
    logic              arb_mem_rd_resp_rdy;
    logic              arb_mem_wr_val;
    logic [DW-1:0]     arb_mem_wr_addr;
    logic [HW-1:0]     arb_mem_wr_data;
    logic              mem_arb_wr_rdy = 1'b0;
`ifdef LOG_HDR_ARB_LOCK_EN
    logic [N-1:0]      cl_lock = '0;
`endif

    log_hdr_mem_arbiter #(.NUM_CLIENTS(N), .TAG_FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
`ifdef LOG_HDR_ARB_LOCK_EN
        .cl_lock              (cl_lock),
`endif
        .cl_rd_req_val        (cl_rd_req_val),
        .cl_rd_req_addr       (cl_rd_req_addr),
        .arb_cl_rd_req_rdy    (arb_cl_rd_req_rdy),
        .arb_cl_rd_resp_val   (arb_cl_rd_resp_val),
        .arb_cl_rd_resp_data  (arb_cl_rd_resp_data),
        .cl_rd_resp_rdy       (cl_rd_resp_rdy),
        .cl_wr_val            (cl_wr_val),
        .cl_wr_addr           (cl_wr_addr),
        .cl_wr_data           (cl_wr_data),
        .arb_cl_wr_rdy        (arb_cl_wr_rdy),
        .arb_mem_rd_req_val   (arb_mem_rd_req_val),
        .arb_mem_rd_req_addr  (arb_mem_rd_req_addr),
        .mem_arb_rd_req_rdy   (mem_arb_rd_req_rdy),
        .mem_arb_rd_resp_val  (mem_arb_rd_resp_val),
        .mem_arb_rd_resp_data (mem_arb_rd_resp_data),
        .arb_mem_rd_resp_rdy  (arb_mem_rd_resp_rdy),
        .arb_mem_wr_val       (arb_mem_wr_val),
        .arb_mem_wr_addr      (arb_mem_wr_addr),
        .arb_mem_wr_data      (arb_mem_wr_data),
        .mem_arb_wr_rdy       (mem_arb_wr_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference state: RR pointers, the ordered list of outstanding reads, memory image, memory's pending replies.
    int            rd_ptr_m = 0;
    int            wr_ptr_m = 0;
    int            exp_cl[$];
    logic [HW-1:0] exp_dat[$];
    logic [HW-1:0] memq[$];
    logic [HW-1:0] mem_m [1 << DW];

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] rvec(input int pct);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < pct);
        return v;
    endfunction

    task automatic run_cycle(input int p_rdv, input int p_wrv, input int p_mrdy,
                             input int p_resp, input int p_clrdy, input bit do_rst);
        int            rg, wg, h;
        bit            full, wr_hs, hazard, rd_go, rd_hs, resp_hs, e_resp_rdy;
        logic [DW-1:0] ra, wa;
        logic [HW-1:0] wd;
        logic [N-1:0]  one, e_rd_rdy, e_wr_rdy, e_resp_vec;

        @(negedge clk);
        rst           = do_rst;
        cl_rd_req_val = rvec(p_rdv);
        cl_wr_val     = rvec(p_wrv);
        for (int i = 0; i < N; i++) begin
            cl_rd_req_addr[i*DW +: DW] = DW'($urandom_range(7));
            cl_wr_addr[i*DW +: DW]     = DW'($urandom_range(7));
            cl_wr_data[i*HW +: HW]     = {$urandom, $urandom};
        end
        cl_rd_resp_rdy       = rvec(p_clrdy);
        mem_arb_rd_req_rdy   = ($urandom_range(99) < p_mrdy);
        mem_arb_wr_rdy       = ($urandom_range(99) < p_mrdy);
        mem_arb_rd_resp_val  = (memq.size() > 0) && ($urandom_range(99) < p_resp);
        mem_arb_rd_resp_data = (memq.size() > 0) ? memq[0] : {$urandom, $urandom};
        #1;

        if (do_rst) begin
            check_val("rst_outputs", 64'({arb_mem_rd_req_val, arb_mem_wr_val, arb_mem_rd_resp_rdy,
                       arb_cl_rd_req_rdy, arb_cl_wr_rdy, arb_cl_rd_resp_val}), 64'd0);
            rd_ptr_m = 0;
            wr_ptr_m = 0;
            exp_cl.delete();
            exp_dat.delete();
            return;
        end

        one = 1;
        wg  = rr_pick(cl_wr_val, wr_ptr_m);
        rg  = rr_pick(cl_rd_req_val, rd_ptr_m);
        wa  = (wg >= 0) ? cl_wr_addr[wg*DW +: DW] : '0;
        wd  = (wg >= 0) ? cl_wr_data[wg*HW +: HW] : '0;
        ra  = (rg >= 0) ? cl_rd_req_addr[rg*DW +: DW] : '0;

        full     = (exp_cl.size() >= DEPTH);
        wr_hs    = (wg >= 0) && mem_arb_wr_rdy;
        hazard   = wr_hs && (rg >= 0) && (ra == wa);
        rd_go    = (rg >= 0) && !full && !hazard;
        rd_hs    = rd_go && mem_arb_rd_req_rdy;
        e_rd_rdy = rd_hs ? (one << rg) : '0;
        e_wr_rdy = wr_hs ? (one << wg) : '0;

        check_val("wr_val", 64'(arb_mem_wr_val), 64'(wg >= 0));
        if (wg >= 0) begin
            check_val("wr_addr", 64'(arb_mem_wr_addr), 64'(wa));
            check_val("wr_data", arb_mem_wr_data, wd);
        end
        check_val("cl_wr_rdy", 64'(arb_cl_wr_rdy), 64'(e_wr_rdy));
        check_val("rd_req_val", 64'(arb_mem_rd_req_val), 64'(rd_go));
        if (rd_go) check_val("rd_req_addr", 64'(arb_mem_rd_req_addr), 64'(ra));
        check_val("cl_rd_rdy", 64'(arb_cl_rd_req_rdy), 64'(e_rd_rdy));

        if (exp_cl.size() == 0) begin
            e_resp_rdy = 1'b1;
            e_resp_vec = '0;
        end else begin
            h          = exp_cl[0];
            e_resp_rdy = cl_rd_resp_rdy[h];
            e_resp_vec = mem_arb_rd_resp_val ? (one << h) : '0;
        end
        check_val("resp_rdy", 64'(arb_mem_rd_resp_rdy), 64'(e_resp_rdy));
        check_val("cl_resp_val", 64'(arb_cl_rd_resp_val), 64'(e_resp_vec));

        resp_hs = mem_arb_rd_resp_val && e_resp_rdy;
        if (resp_hs) begin
            void'(memq.pop_front());
            if (exp_cl.size() > 0) begin
                check_val("resp_data", arb_cl_rd_resp_data, exp_dat[0]);
                void'(exp_cl.pop_front());
                void'(exp_dat.pop_front());
            end
        end
        if (rd_hs) begin
            exp_cl.push_back(rg);
            exp_dat.push_back(mem_m[ra]);
            memq.push_back(mem_m[ra]);
            rd_ptr_m = (rg + 1) % N;
        end
        if (wr_hs) begin
            mem_m[wa] = wd;
            wr_ptr_m  = (wg + 1) % N;
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << DW); a++) mem_m[a] = {32'hA5A5_0000 + 32'(a), 32'(a) * 32'h1000_0001};

        repeat (3) run_cycle(50, 50, 50, 50, 50, 1'b1);

        // Every client reading back-to-back with everything ready: strict 0,1,2 rotation.
        repeat (20) run_cycle(100, 0, 100, 100, 100, 1'b0);
        // Withhold responses until the tag queue fills, then release them slowly.
        repeat (10) run_cycle(80, 0, 100, 0, 100, 1'b0);
        repeat (30) run_cycle(80, 20, 100, 40, 60, 1'b0);
        // Dense same-address traffic to provoke write/read collisions.
        repeat (400) run_cycle(70, 70, 90, 60, 70, 1'b0);
        // Mixed randomized traffic with varying backpressure.
        for (int p = 0; p < 6; p++) begin
            repeat (300) run_cycle($urandom_range(10, 100), $urandom_range(0, 90), $urandom_range(20, 100),
                                   $urandom_range(10, 100), $urandom_range(10, 100), 1'b0);
        end

        // Leave reads outstanding, reset, then let the memory return its stale replies with no new reads.
        repeat (6) run_cycle(100, 0, 100, 0, 100, 1'b0);
        check_val("outstanding_before_rst", 64'(exp_cl.size() >= 2), 64'd1);
        repeat (2) run_cycle(50, 50, 50, 0, 50, 1'b1);
        begin
            int budget = 50;
            while (memq.size() > 0 && budget > 0) begin
                run_cycle(0, 0, 100, 100, 50, 1'b0);
                budget--;
            end
            check_val("late_resp_drained", 64'(memq.size()), 64'd0);
        end

        repeat (800) run_cycle(60, 50, 80, 60, 70, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
